// File: rtl/prio_arbiter_n.sv
// N-way request arbiter with registered grant outputs, fixed-priority or
// round-robin selection, hold-until-ack semantics and an optional grant timeout.
module prio_arbiter_n #(
    parameter int N       = 8,
    parameter int IDXW    = $clog2(N),
    parameter int MODE    = 0,
    parameter int TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [N-1:0]    req,
    input  logic            ack,
    output logic            valid,
    output logic [IDXW-1:0] grant_idx,
    output logic [N-1:0]    grant_onehot,
    output logic            timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    oh_q, oh_d;
    logic            to_q, to_d;
    logic [IDXW-1:0] nxt_ptr_s;
    logic [IDXW-1:0] arb_ptr_s;
    logic [IDXW-1:0] win_s;
    logic            any_s;
    logic            load_s;
    logic            expire_s;

    // Highest set index wins, matching the legacy 4-to-2 encoder ordering.
    function automatic logic [IDXW-1:0] pick_fixed(input logic [N-1:0] r);
        logic [IDXW-1:0] w;
        w = {IDXW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                w = IDXW'(i);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    function automatic logic [IDXW-1:0] pick_rr(input logic [N-1:0] r, input logic [IDXW-1:0] p);
        logic [IDXW-1:0] w;
        logic            found;
        int              j;
        w     = {IDXW{1'b0}};
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(p) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (!found && r[IDXW'(j)]) begin
                w     = IDXW'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return w;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] i);
        logic [N-1:0] o;
        o    = {N{1'b0}};
        o[i] = 1'b1;
        return o;
    endfunction

    assign any_s     = |req;
    assign nxt_ptr_s = (idx_q == IDXW'(N - 1)) ? {IDXW{1'b0}} : idx_q + IDXW'(1);
    // A back-to-back re-arbitration must already see the pointer advanced past
    // the grant that is completing in the same cycle.
    assign arb_ptr_s = (state_q == ST_GRANT) ? nxt_ptr_s : ptr_q;

    // Winner selection for the configured mode.
    always_comb begin
        win_s = {IDXW{1'b0}};
        if (MODE == 1) begin
            win_s = pick_rr(req, arb_ptr_s);
        end else begin
            win_s = pick_fixed(req);
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(TIMEOUT + 1);
            logic [CW-1:0] cnt_q;

            // Wait counter for the held grant; cleared on every new load.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_q <= {CW{1'b0}};
                end else if (load_s || (state_q != ST_GRANT)) begin
                    cnt_q <= {CW{1'b0}};
                end else if (!ack) begin
                    cnt_q <= cnt_q + CW'(1);
                end else begin
                    cnt_q <= cnt_q;
                end
            end

            assign expire_s = (state_q == ST_GRANT) && !ack && (cnt_q == CW'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign expire_s = 1'b0;
        end
    endgenerate

    // Next-state and next-output logic; ack takes precedence over expiry.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        to_d    = 1'b0;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_s) begin
                    load_s  = 1'b1;
                    state_d = ST_GRANT;
                    valid_d = 1'b1;
                    idx_d   = win_s;
                    oh_d    = to_onehot(win_s);
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    idx_d   = {IDXW{1'b0}};
                    oh_d    = {N{1'b0}};
                end
            end
            ST_GRANT: begin
                if (ack) begin
                    ptr_d = nxt_ptr_s;
                    if (any_s) begin
                        load_s  = 1'b1;
                        state_d = ST_GRANT;
                        valid_d = 1'b1;
                        idx_d   = win_s;
                        oh_d    = to_onehot(win_s);
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        idx_d   = {IDXW{1'b0}};
                        oh_d    = {N{1'b0}};
                    end
                end else if (expire_s) begin
                    ptr_d   = nxt_ptr_s;
                    to_d    = 1'b1;
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    idx_d   = {IDXW{1'b0}};
                    oh_d    = {N{1'b0}};
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = {IDXW{1'b0}};
                oh_d    = {N{1'b0}};
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            idx_q   <= {IDXW{1'b0}};
            oh_q    <= {N{1'b0}};
            ptr_q   <= {IDXW{1'b0}};
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
            to_q    <= to_d;
        end
    end

    assign valid        = valid_q;
    assign grant_idx    = idx_q;
    assign grant_onehot = oh_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Bench for prio_arbiter_n: three N=4 instances (fixed, round-robin,
// round-robin with TIMEOUT=8) driven by directed and random stimulus.
module tb_prio_arbiter_n;

    logic       clk;
    logic       rstn;
    logic [3:0] req_s [3];
    logic       ack_s [3];
    logic       v_s   [3];
    logic [1:0] idx_s [3];
    logic [3:0] oh_s  [3];
    logic       to_s  [3];

    int checks = 0;
    int errors = 0;

    // Reference model state, one entry per instance.
    int m_v   [3];
    int m_idx [3];
    int m_ptr [3];
    int m_age [3];
    int m_to  [3];
    int m_mode[3] = '{0, 1, 1};
    int m_tmo [3] = '{0, 0, 8};

    prio_arbiter_n #(.N(4), .MODE(0), .TIMEOUT(0)) u0 (
        .clk(clk), .rstn(rstn), .req(req_s[0]), .ack(ack_s[0]),
        .valid(v_s[0]), .grant_idx(idx_s[0]), .grant_onehot(oh_s[0]), .timeout(to_s[0]));
    prio_arbiter_n #(.N(4), .MODE(1), .TIMEOUT(0)) u1 (
        .clk(clk), .rstn(rstn), .req(req_s[1]), .ack(ack_s[1]),
        .valid(v_s[1]), .grant_idx(idx_s[1]), .grant_onehot(oh_s[1]), .timeout(to_s[1]));
    prio_arbiter_n #(.N(4), .MODE(1), .TIMEOUT(8)) u2 (
        .clk(clk), .rstn(rstn), .req(req_s[2]), .ack(ack_s[2]),
        .valid(v_s[2]), .grant_idx(idx_s[2]), .grant_onehot(oh_s[2]), .timeout(to_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int winner(input logic [3:0] r, input int mode, input int ptr);
        if (mode == 0) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int u = 0; u < 3; u++) begin
            m_v[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_age[u] = 0; m_to[u] = 0;
        end
    endtask

    task automatic model_step(input int u, input logic [3:0] r, input logic a);
        m_to[u] = 0;
        if (m_v[u] == 1 && a) begin
            m_ptr[u] = (m_idx[u] + 1) % 4;
            m_v[u] = 0; m_idx[u] = 0;
            if (r != 4'd0) begin
                m_v[u] = 1; m_idx[u] = winner(r, m_mode[u], m_ptr[u]); m_age[u] = 0;
            end
        end else if (m_v[u] == 1 && m_tmo[u] > 0 && m_age[u] == m_tmo[u] - 1) begin
            m_ptr[u] = (m_idx[u] + 1) % 4;
            m_v[u] = 0; m_idx[u] = 0; m_to[u] = 1;
        end else if (m_v[u] == 1) begin
            m_age[u] = m_age[u] + 1;
        end else if (r != 4'd0) begin
            m_v[u] = 1; m_idx[u] = winner(r, m_mode[u], m_ptr[u]); m_age[u] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int u = 0; u < 3; u++) begin
            req_s[u] = 4'd0; ack_s[u] = 1'b0;
        end
        tick(); tick();
        for (int u = 0; u < 3; u++) begin
            checks++;
            if ({v_s[u], idx_s[u], oh_s[u], to_s[u]} !== 8'd0) begin
                errors++;
                $display("FAIL reset u%0d got v=%b idx=%0d oh=%b to=%b want all zero",
                         u, v_s[u], idx_s[u], oh_s[u], to_s[u]);
            end
        end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_fixed_sweep();
        logic [3:0] pat [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        int         eix [5] = '{0, 0, 1, 2, 3};
        for (int k = 0; k < 5; k++) begin
            req_s[0] = pat[k]; ack_s[0] = 1'b1;
            tick();
            checks++;
            if (v_s[0] !== (pat[k] != 4'd0) || idx_s[0] !== 2'(eix[k]) || oh_s[0] !== pat[k]) begin
                errors++;
                $display("FAIL fixed_sweep req=%b got v=%b idx=%0d oh=%b want v=%b idx=%0d oh=%b",
                         pat[k], v_s[0], idx_s[0], oh_s[0], pat[k] != 4'd0, eix[k], pat[k]);
            end
        end
        req_s[0] = 4'd0;
        tick();
        ack_s[0] = 1'b0;
        checks++;
        if (v_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL fixed_sweep_release got v=%b want 0", v_s[0]);
        end
    endtask

    task automatic test_fixed_b2b();
        req_s[0] = 4'b1111; ack_s[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (v_s[0] !== 1'b1 || idx_s[0] !== 2'd3 || oh_s[0] !== 4'b1000) begin
                errors++;
                $display("FAIL fixed_b2b cyc%0d got v=%b idx=%0d oh=%b want v=1 idx=3 oh=1000",
                         k, v_s[0], idx_s[0], oh_s[0]);
            end
        end
        req_s[0] = 4'd0;
        tick();
        ack_s[0] = 1'b0;
    endtask

    task automatic test_rr_rotation();
        logic [3:0] pat [9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                4'b1010, 4'b1010, 4'b1010, 4'b1010};
        int         eix [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
        ack_s[1] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            req_s[1] = pat[k];
            tick();
            checks++;
            if (v_s[1] !== 1'b1 || idx_s[1] !== 2'(eix[k]) || oh_s[1] !== (4'b0001 << eix[k])) begin
                errors++;
                $display("FAIL rr_rotation step%0d got v=%b idx=%0d oh=%b want v=1 idx=%0d",
                         k, v_s[1], idx_s[1], oh_s[1], eix[k]);
            end
        end
        req_s[1] = 4'd0;
        tick();
        ack_s[1] = 1'b0;
    endtask

    task automatic test_hold_on_drop();
        req_s[0] = 4'b0100; ack_s[0] = 1'b0;
        tick();
        req_s[0] = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (v_s[0] !== 1'b1 || idx_s[0] !== 2'd2 || oh_s[0] !== 4'b0100) begin
                errors++;
                $display("FAIL hold_on_drop cyc%0d got v=%b idx=%0d want v=1 idx=2",
                         k, v_s[0], idx_s[0]);
            end
            if (k < 5) tick();
        end
        ack_s[0] = 1'b1;
        tick();
        ack_s[0] = 1'b0;
        checks++;
        if (v_s[0] !== 1'b0 || idx_s[0] !== 2'd0 || oh_s[0] !== 4'd0) begin
            errors++;
            $display("FAIL hold_release got v=%b idx=%0d oh=%b want 0", v_s[0], idx_s[0], oh_s[0]);
        end
        // ack with nothing granted must not start or disturb anything
        ack_s[0] = 1'b1;
        tick(); tick();
        ack_s[0] = 1'b0;
        checks++;
        if (v_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack got v=%b want 0", v_s[0]);
        end
    endtask

    task automatic test_timeout();
        req_s[2] = 4'b0001; ack_s[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (v_s[2] !== 1'b1 || idx_s[2] !== 2'd0 || to_s[2] !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold cyc%0d got v=%b idx=%0d to=%b want v=1 idx=0 to=0",
                         k, v_s[2], idx_s[2], to_s[2]);
            end
        end
        tick();
        checks++;
        if (to_s[2] !== 1'b1 || v_s[2] !== 1'b0 || oh_s[2] !== 4'd0) begin
            errors++;
            $display("FAIL timeout_pulse got to=%b v=%b oh=%b want to=1 v=0 oh=0000",
                     to_s[2], v_s[2], oh_s[2]);
        end
        req_s[2] = 4'b0011;
        tick();
        checks++;
        if (to_s[2] !== 1'b0 || v_s[2] !== 1'b1 || idx_s[2] !== 2'd1) begin
            errors++;
            $display("FAIL timeout_ptr got to=%b v=%b idx=%0d want to=0 v=1 idx=1",
                     to_s[2], v_s[2], idx_s[2]);
        end
        // Let the counter reach its last cycle, then ack exactly there
        for (int k = 0; k < 7; k++) tick();
        req_s[2] = 4'd0; ack_s[2] = 1'b1;
        tick();
        ack_s[2] = 1'b0;
        checks++;
        if (to_s[2] !== 1'b0 || v_s[2] !== 1'b0) begin
            errors++;
            $display("FAIL ack_beats_timeout got to=%b v=%b want to=0 v=0", to_s[2], v_s[2]);
        end
    endtask

    task automatic test_async_reset();
        req_s[0] = 4'b1000; ack_s[0] = 1'b0;
        tick();
        checks++;
        if (v_s[0] !== 1'b1 || idx_s[0] !== 2'd3) begin
            errors++;
            $display("FAIL async_pre got v=%b idx=%0d want v=1 idx=3", v_s[0], idx_s[0]);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (v_s[0] !== 1'b0 || idx_s[0] !== 2'd0 || oh_s[0] !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b idx=%0d oh=%b want 0 before edge",
                     v_s[0], idx_s[0], oh_s[0]);
        end
        req_s[0] = 4'd0;
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({v_s[0], idx_s[0], oh_s[0], to_s[0]} !== 8'd0) begin
                errors++;
                $display("FAIL post_reset cyc%0d got v=%b idx=%0d oh=%b want 0",
                         k, v_s[0], idx_s[0], oh_s[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] r [3];
        logic       a [3];
        logic [3:0] eoh;
        rstn = 1'b0;
        for (int u = 0; u < 3; u++) begin
            req_s[u] = 4'd0; ack_s[u] = 1'b0;
        end
        tick();
        rstn = 1'b1;
        model_reset();
        tick();
        for (int c = 0; c < 600; c++) begin
            for (int u = 0; u < 3; u++) begin
                r[u] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                a[u] = ($urandom_range(0, 3) == 0);
                req_s[u] = r[u]; ack_s[u] = a[u];
            end
            tick();
            for (int u = 0; u < 3; u++) begin
                model_step(u, r[u], a[u]);
                eoh = (m_v[u] == 1) ? (4'b0001 << m_idx[u]) : 4'b0000;
                checks++;
                if ({v_s[u], idx_s[u], oh_s[u], to_s[u]} !==
                    {m_v[u] == 1, 2'(m_idx[u]), eoh, m_to[u] == 1}) begin
                    errors++;
                    $display("FAIL random u%0d cyc%0d got v=%b idx=%0d oh=%b to=%b want v=%0d idx=%0d oh=%b to=%0d",
                             u, c, v_s[u], idx_s[u], oh_s[u], to_s[u], m_v[u], m_idx[u], eoh, m_to[u]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_sweep();
        test_fixed_b2b();
        test_rr_rotation();
        test_hold_on_drop();
        test_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
